// File: rtl/oam_dma_if.sv
// Bus bundle between the sprite-DMA engine, the CPU bus, memory and the PPU register port.
// There is no valid/ready pair: every signal is qualified by cpu_ce, and a value counts only at the clk where cpu_ce=1.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_rw;
    logic        cpu_halt;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  mem_rdata;
    logic [2:0]  ppu_reg_selc;
    logic [7:0]  ppu_data;
    logic        ppu_read_write;
    logic        ppu_sel;

    modport master (
        input  cpu_addr, cpu_data, cpu_rw, mem_rdata,
        output cpu_halt, dma_addr, dma_rd, ppu_reg_selc, ppu_data, ppu_read_write, ppu_sel
    );

    modport slave (
        output cpu_addr, cpu_data, cpu_rw, mem_rdata,
        input  cpu_halt, dma_addr, dma_rd, ppu_reg_selc, ppu_data, ppu_read_write, ppu_sel
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite-DMA engine: a $4014 write halts the CPU and copies page P ($P00-$PFF) into OAM
// through OAMDATA writes, alternating get (read) and put (write) CPU cycles.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [2:0]  OAMDATA_SEL  = 3'd4,
    parameter int          XFER_LEN     = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_ce,
    oam_dma_if.master  bus,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_cyc_odd;
    logic [7:0]  r_page;
    logic [7:0]  w_next_page;
    logic [7:0]  r_idx;
    logic [7:0]  w_next_idx;
    logic        w_trigger;
    logic        w_last;

    logic        w_busy;
    logic        w_dma_rd;
    logic [15:0] w_dma_addr;
    logic        w_ppu_wr;
    logic [7:0]  w_ppu_data;
    logic [2:0]  w_ppu_selc;

    logic        r_busy;
    logic        r_done;
    logic        r_dma_rd;
    logic [15:0] r_dma_addr;
    logic        r_ppu_rw;
    logic [7:0]  r_ppu_data;
    logic [2:0]  r_ppu_selc;

    assign w_trigger = (bus.cpu_rw == 1'b0) && (bus.cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cyc_odd <= 1'b0;
            r_page    <= 8'h00;
            r_idx     <= 8'h00;
        end else if (cpu_ce) begin
            r_state   <= w_next_state;
            r_cyc_odd <= ~r_cyc_odd;
            r_page    <= w_next_page;
            r_idx     <= w_next_idx;
        end
    end

    // The trigger is only looked at in IDLE, so a $4014 write mid-transfer has no effect.
    always_comb begin
        w_next_state = r_state;
        w_next_page  = r_page;
        w_next_idx   = r_idx;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_next_state = S_HALT;
                    w_next_page  = bus.cpu_data;
                    w_next_idx   = 8'h00;
                end
            end
            // r_cyc_odd=1 now means the upcoming cycle is a get cycle.
            S_HALT:  w_next_state = r_cyc_odd ? S_READ : S_ALIGN;
            S_ALIGN: w_next_state = S_READ;
            S_READ:  w_next_state = S_WRITE;
            S_WRITE: begin
                if (r_idx == LAST_IDX) begin
                    w_next_state = S_IDLE;
                    w_last       = 1'b1;
                end else begin
                    w_next_idx   = r_idx + 8'd1;
                    w_next_state = S_READ;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines up with the state register.
    always_comb begin
        w_busy     = (w_next_state != S_IDLE);
        w_dma_rd   = (w_next_state == S_READ);
        w_dma_addr = w_dma_rd ? {w_next_page, w_next_idx} : 16'h0000;
        w_ppu_wr   = (w_next_state == S_WRITE);
        w_ppu_data = w_ppu_wr ? bus.mem_rdata : 8'h00;
        w_ppu_selc = w_ppu_wr ? OAMDATA_SEL : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dma_rd   <= 1'b0;
            r_dma_addr <= 16'h0000;
            r_ppu_rw   <= 1'b1;
            r_ppu_data <= 8'h00;
            r_ppu_selc <= 3'd0;
        end else begin
            r_done <= 1'b0;
            if (cpu_ce) begin
                r_busy     <= w_busy;
                r_done     <= w_last;
                r_dma_rd   <= w_dma_rd;
                r_dma_addr <= w_dma_addr;
                r_ppu_rw   <= ~w_ppu_wr;
                r_ppu_data <= w_ppu_data;
                r_ppu_selc <= w_ppu_selc;
            end
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign dbg_state          = r_state;
    assign bus.cpu_halt       = r_busy;
    assign bus.ppu_sel        = r_busy;
    assign bus.dma_rd         = r_dma_rd;
    assign bus.dma_addr       = r_dma_addr;
    assign bus.ppu_read_write = r_ppu_rw;
    assign bus.ppu_data       = r_ppu_data;
    assign bus.ppu_reg_selc   = r_ppu_selc;
endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a cycle-accurate model of busy/read/write timing plus a
// scoreboard of expected read addresses and OAMDATA bytes pushed at each trigger.
module tb_oam_dma;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_ce = 1'b0;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  oam_dma_if bus ();

  oam_dma dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ce    (cpu_ce),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Memory model: each byte is its address low byte XOR $A5.
  assign bus.mem_rdata = bus.dma_addr[7:0] ^ 8'hA5;

  always #5 clk = ~clk;

  int ce_base = 3;
  bit ce_jit = 1'b0;

  initial begin
    int gap;
    forever begin
      gap = ce_base + (ce_jit ? int'($urandom_range(1, 3)) : 0);
      repeat (gap) @(posedge clk);
      #1 cpu_ce = 1'b1;
      @(posedge clk);
      #1 cpu_ce = 1'b0;
    end
  end

  logic [7:0]  exp_data_q[$];
  logic [15:0] exp_addr_q[$];

  int n_checks = 0;
  int n_err = 0;
  int cur_cyc = 0;
  int xfer_start = -1000;
  int exp_len = 0;
  int first_rd = -1000;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [15:0] last_rd_addr = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic sample();
    logic exp_busy;
    logic exp_rd;
    logic exp_wr;
    logic [15:0] ea;
    logic [7:0] ed;
    int off;
    exp_busy = (cur_cyc >= xfer_start) && (cur_cyc < xfer_start + exp_len);
    off = cur_cyc - first_rd;
    exp_rd = exp_busy && (off >= 0) && (off % 2 == 0);
    exp_wr = exp_busy && (off >= 0) && (off % 2 == 1);
    check("busy", 32'(busy), 32'(exp_busy));
    check("cpu_halt", 32'(bus.cpu_halt), 32'(exp_busy));
    check("ppu_sel", 32'(bus.ppu_sel), 32'(exp_busy));
    check("dma_rd", 32'(bus.dma_rd), 32'(exp_rd));
    check("ppu_read_write", 32'(bus.ppu_read_write), 32'(!exp_wr));
    if (busy) busy_cnt++;
    if (bus.dma_rd) last_rd_addr = bus.dma_addr;
    if (exp_rd) begin
      ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 16'hxxxx;
      check("dma_addr", 32'(bus.dma_addr), 32'(ea));
    end
    if (exp_wr) begin
      ed = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 8'hxx;
      check("ppu_data", 32'(bus.ppu_data), 32'(ed));
      check("ppu_reg_selc", 32'(bus.ppu_reg_selc), 32'd4);
    end
    if (!exp_busy) begin
      check("idle_dma_addr", 32'(bus.dma_addr), 32'd0);
      check("idle_ppu_data", 32'(bus.ppu_data), 32'd0);
      check("idle_ppu_reg_selc", 32'(bus.ppu_reg_selc), 32'd0);
    end
  endtask

  // Advance one CPU cycle: sample the cycle at the negedge inside its cpu_ce clk, then pass the edge.
  task automatic step();
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (!rst && done) done_cnt++;
      if (cpu_ce) break;
      guard++;
      if (guard > 64) begin
        n_checks++;
        n_err++;
        $display("FAIL ce_timeout: observed=no cpu_ce expected=cpu_ce within 64 clks");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "cpu_ce stalled");
      end
    end
    if (!rst) sample();
    @(posedge clk);
    #1;
    cur_cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cur_cyc = 0;
    xfer_start = -1000;
    first_rd = -1000;
    exp_len = 0;
    done_cnt = 0;
    busy_cnt = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    check("rst_dbg_state", 32'(dbg_state), 32'd0);
    check("rst_done", 32'(done), 32'd0);
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    bus.cpu_addr = addr;
    bus.cpu_data = data;
    bus.cpu_rw = 1'b0;
    step();
    bus.cpu_addr = 16'h0000;
    bus.cpu_data = 8'h00;
    bus.cpu_rw = 1'b1;
  endtask

  // Trigger page at cycle trig; optional intruding $4014<=$07 at cycle intr; stop early at cycle stop.
  task automatic run_xfer(input logic [7:0] page, input int trig, input int intr, input int stop);
    for (int i = 0; i < 256; i++) begin
      exp_addr_q.push_back({page, 8'(i)});
      exp_data_q.push_back(8'(i) ^ 8'hA5);
    end
    while (cur_cyc < trig) step();
    xfer_start = trig + 1;
    exp_len = (trig % 2 == 1) ? 514 : 513;
    first_rd = trig + ((trig % 2 == 1) ? 3 : 2);
    done_cnt = 0;
    busy_cnt = 0;
    cpu_write(16'h4014, page);
    if (intr > 0) begin
      while (cur_cyc < intr) step();
      cpu_write(16'h4014, 8'h07);
    end
    if (stop > 0) begin
      while (cur_cyc < stop) step();
    end else begin
      while (cur_cyc < xfer_start + exp_len + 2) step();
      check("done_count", 32'(done_cnt), 32'd1);
      check("busy_cycles", 32'(busy_cnt), 32'(exp_len));
      check("last_read_addr", 32'(last_rd_addr), 32'({page, 8'hFF}));
      check("reads_left", 32'(exp_addr_q.size()), 32'd0);
      check("writes_left", 32'(exp_data_q.size()), 32'd0);
    end
  endtask

  initial begin
    bus.cpu_addr = 16'h0000;
    bus.cpu_data = 8'h00;
    bus.cpu_rw = 1'b1;

    // Trigger on get cycle 4: HALT is a put cycle, 513 cycles.
    do_reset();
    run_xfer(8'h02, 4, -1, -1);

    // Trigger on put cycle 5 plus an ignored retrigger at idx=$40: ALIGN inserted, 514 cycles.
    do_reset();
    run_xfer(8'h02, 5, 136, -1);

    // Reset during the WRITE of idx=$80 (cycle 263).
    do_reset();
    run_xfer(8'h02, 4, -1, 263);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_cpu_halt", 32'(bus.cpu_halt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ppu_sel", 32'(bus.ppu_sel), 32'd0);
    check("midrst_ppu_rw", 32'(bus.ppu_read_write), 32'd1);
    check("midrst_dma_rd", 32'(bus.dma_rd), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    step();
    rst = 1'b0;
    cur_cyc = 0;
    xfer_start = -1000;
    first_rd = -1000;
    done_cnt = 0;
    check("midrst_writes_left", 32'(exp_data_q.size()), 32'd128);
    check("midrst_reads_left", 32'(exp_addr_q.size()), 32'd127);
    repeat (10) step();
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_no_writes", 32'(exp_data_q.size()), 32'd128);
    exp_addr_q.delete();
    exp_data_q.delete();
    run_xfer(8'h03, 12, -1, -1);

    // Page $FF with slow, jittered cpu_ce, both parities.
    ce_base = 11;
    ce_jit = 1'b1;
    do_reset();
    run_xfer(8'hFF, 4, -1, -1);
    do_reset();
    run_xfer(8'hFF, 5, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
